// File: rtl/rr_stream_mux_if.sv
// Stream bundle between N producers, the round-robin mux and one consumer.
// Optional packet framing (in_last/out_last) is present only with RR_STREAM_MUX_PKT_LOCK_EN.
interface rr_stream_mux_if #(
  parameter int N = 16,
  parameter int W = 8
) ();
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic [SELW-1:0] out_sel;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic [N-1:0]    in_last;
  logic            out_last;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_sel, out_last
  );
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_sel, out_last
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_sel
  );
  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_sel
  );
`endif
endinterface

// File: rtl/rr_stream_mux.sv
// N-to-1 round-robin stream mux, registered output, 1-cycle latency, full throughput.
// Optional packet locking via RR_STREAM_MUX_PKT_LOCK_EN; stalls hold output and drop all in_ready.
module rr_stream_mux #(
  parameter int N = 16,
  parameter int W = 8
) (
  input logic           clk,
  input logic           rst,
  rr_stream_mux_if.slave bus
);
  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [W-1:0]    out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  logic            lock_q, lock_d;
  logic            out_last_q, out_last_d;
`endif

  logic            load;
  logic            gnt_vld;
  logic [SELW-1:0] gnt_idx;
  logic [SELW-1:0] ptr_adv;

  assign load = ~out_valid_q | bus.out_ready;

  always_comb begin
    int c;
    c       = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (load) begin
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      // The locked channel is always the one that supplied the held word.
      if (lock_q) begin
        gnt_vld = bus.in_valid[out_sel_q];
        gnt_idx = out_sel_q;
      end else
`endif
      begin
        // Scan from farthest offset down so the closest valid channel to ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
          c = int'(ptr_q) + k;
          if (c >= N) c = c - N;
          if (bus.in_valid[c]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(c);
          end
        end
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    if (gnt_vld) bus.in_ready[gnt_idx] = 1'b1;
  end

  assign ptr_adv = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (gnt_vld) begin
      out_data_d  = bus.in_data[int'(gnt_idx)*W +: W];
      out_valid_d = 1'b1;
      out_sel_d   = gnt_idx;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      out_last_d  = bus.in_last[gnt_idx];
      if (bus.in_last[gnt_idx]) begin
        lock_d = 1'b0;
        ptr_d  = ptr_adv;
      end else begin
        lock_d = 1'b1;
      end
`else
      ptr_d       = ptr_adv;
`endif
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sel   = out_sel_q;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
  assign bus.out_last  = out_last_q;
`endif
endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-free behavioural model.
module tb_rr_stream_mux;
  localparam int N = 16;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_stream_mux_if #(.N(N), .W(W)) bus ();
  rr_stream_mux #(.N(N), .W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state: the word the sink should see, and whose turn it is.
  logic [W-1:0] m_dat;
  logic         m_vld;
  int           m_sel;
  int           m_ptr;
  logic         m_lock;
  logic         m_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_dat = '0; m_vld = 1'b0; m_sel = 0; m_ptr = 0; m_lock = 1'b0; m_last = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] d);
    bus.in_data[ch*W +: W] = d;
  endtask

  // One clock: inputs already driven; check, let the edge pass, update the model.
  task automatic step();
    logic [N-1:0] er;
    int g;
    bit ld;
    #1;
    ld = !m_vld || bus.out_ready;
    g  = -1;
    if (ld) begin
      if (m_lock) begin
        if (bus.in_valid[m_sel]) g = m_sel;
      end else begin
        for (int k = 0; k < N; k++)
          if (g < 0 && bus.in_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("in_ready", bus.in_ready, er);
    chk("out_valid", bus.out_valid, m_vld);
    chk("out_data", bus.out_data, m_dat);
    chk("out_sel", bus.out_sel, m_sel);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    chk("out_last", bus.out_last, m_last);
`endif
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (g >= 0) begin
      m_dat = bus.in_data[g*W +: W];
      m_sel = g;
      m_vld = 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      m_last = bus.in_last[g];
      m_lock = !bus.in_last[g];
      if (!m_lock) m_ptr = (g + 1) % N;
`else
      m_ptr = (g + 1) % N;
`endif
    end else if (m_vld && bus.out_ready) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    bus.in_data   = '0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    bus.in_last   = '1;
`endif
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state visible on the first cycle after release.
    #1;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_sel", bus.out_sel, 0);
    chk("rst_ready", bus.in_ready, 0);
    step();

    // Every channel valid: strict rotation with no bubbles.
    for (int i = 0; i < N; i++) set_ch(i, W'(8'h10 + i));
    bus.in_valid = '1;
    for (int j = 0; j <= N; j++) begin
      step();
      chk("rot_valid", bus.out_valid, 1);
      chk("rot_data", bus.out_data, 8'h10 + (j % N));
      chk("rot_sel", bus.out_sel, j % N);
    end

    // Two sparse channels alternate.
    bus.in_valid = '0;
    bus.in_valid[3] = 1'b1;
    bus.in_valid[12] = 1'b1;
    set_ch(3, 8'h33);
    set_ch(12, 8'hC2);
    for (int j = 0; j < 4; j++) begin
      step();
      chk("alt_sel", bus.out_sel, (j % 2 == 0) ? 3 : 12);
      chk("alt_data", bus.out_data, (j % 2 == 0) ? 8'h33 : 8'hC2);
    end

    // Stall with a held word from channel 7.
    bus.in_valid = '0;
    bus.in_valid[7] = 1'b1;
    set_ch(7, 8'hA5);
    step();
    chk("hold_data0", bus.out_data, 8'hA5);
    chk("hold_sel0", bus.out_sel, 7);
    bus.in_valid = '1;
    bus.out_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      chk("stall_data", bus.out_data, 8'hA5);
      chk("stall_sel", bus.out_sel, 7);
      chk("stall_valid", bus.out_valid, 1);
      chk("stall_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("resume_ready", bus.in_ready, 16'h0100);
    step();
    chk("resume_sel", bus.out_sel, 8);

    // Reset while holding a word: pointer returns to 0.
    bus.in_valid = '0;
    bus.in_valid[2] = 1'b1;
    bus.in_valid[9] = 1'b1;
    rst = 1'b1;
    step();
    chk("rst5_valid", bus.out_valid, 0);
    rst = 1'b0;
    step();
    chk("rst5_first", bus.out_sel, 2);
    step();
    chk("rst5_second", bus.out_sel, 9);

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    // Three-beat packet from channel 1 stays contiguous.
    bus.in_valid = '0;
    bus.in_valid[0] = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    bus.in_valid = 16'h0007;
    for (int b = 0; b < 3; b++) begin
      bus.in_last = '1;
      bus.in_last[1] = (b == 2);
      step();
      chk("pkt_sel", bus.out_sel, 1);
      chk("pkt_last", bus.out_last, (b == 2) ? 1 : 0);
    end
    bus.in_last = '1;
    step();
    chk("pkt_next", bus.out_sel, 2);
`endif

    // Randomized traffic.
    for (int j = 0; j < 3000; j++) begin
      bus.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid  = (j % 200 < 100) ? N'($urandom & $urandom & $urandom) : N'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 199) == 0);
`ifdef RR_STREAM_MUX_PKT_LOCK_EN
      bus.in_last   = N'($urandom | $urandom);
`endif
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-to-1 streaming multiplexer with registered output and valid/ready handshake on every channel.
- Generalises the fixed 16:1 select-driven mux. The select is produced internally by a fair round-robin arbiter instead of an external sel bus.
- Used wherever several producers share one downstream consumer, for example debug/trace funnels and shared bus masters.
- Full throughput: one word per clock when the sink is ready.

Parameters:
- N, 16, number of input channels, >=1; non-power-of-2 values supported.
- W, 8, data width per channel in bits.
- SELW, (N>1 ? $clog2(N) : 1), width of the channel index; derived value, not overridden by users.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_data  input  N*W  channel i data on bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_ready  output  N  per-channel ready (one-hot or zero)
- out_data  output  W  registered output word
- out_valid  output  1  output word held
- out_ready  input  1  sink accepts out_data this cycle
- out_sel  output  SELW  index of the channel that supplied out_data

Behaviour:
- Reset: synchronous; on rst=1 at a clock edge the following are cleared.
  - out_valid=0, out_data=0, out_sel=0.
  - Round-robin pointer ptr=0, so channel 0 has first priority.
  - Lock state cleared (when the optional feature is compiled in).
  - Any held word is discarded with no handshake.
  - rst overrides all simultaneous activity.
- Load enable: load = ~out_valid | out_ready. The output register accepts a new word whenever it is empty or being drained in the same cycle. This gives back-to-back transfers with no bubble.
- Arbitration:
  - Combinational, runs when load=1.
  - Scans channels ptr, ptr+1, ..., wrapping N-1 -> 0.
  - The first channel with in_valid=1 is the grant g.
- in_ready[g]=1 only when load=1 and a grant exists. All other bits of in_ready are 0.
  - in_ready may depend combinationally on in_valid and out_ready.
  - Sources must not make in_valid depend on in_ready.
- Transfer: on a clock edge with in_valid[g] & in_ready[g], the block updates:
  - out_data<=in_data[g], out_sel<=g, out_valid<=1.
  - ptr<=(g==N-1)?0:g+1.
- Drain: out_valid & out_ready with no new grant -> out_valid<=0. out_data and out_sel keep their last values.
- Stall: while out_valid=1 and out_ready=0, out_data and out_sel are held stable and in_ready is all zeros.
- Latency: 1 clock from input acceptance to out_valid.
- Fairness: a continuously valid channel is granted within N transfers.
- With no in_valid asserted, ptr is unchanged.
- N=1: ptr is constant 0 and the block behaves as a one-entry pipeline register.
- Data is passed unmodified; there is no width conversion.

Optional Feature:
- Macro RR_STREAM_MUX_PKT_LOCK_EN.
- When defined:
  - Adds ports in_last (input, N) and out_last (output, 1; reset 0).
  - out_last is registered alongside out_data.
  - Once channel g transfers a beat with in_last[g]=0, the block sets lock=1 and the arbiter considers only channel g. Other channels see in_ready=0 even if g is idle.
  - ptr does not advance while locked.
  - The beat with in_last[g]=1 clears lock and advances ptr to g+1 (with wrap).
  - Single-beat packets (last=1 on the first beat) never lock.
- When undefined: in_last/out_last do not exist and every beat is arbitrated independently.

Test Plan:
1. Reset, all in_valid=0 -> out_valid=0, out_data=0, out_sel=0, in_ready=0 on the first cycle after rst deasserts.
2. N=16, W=8, all channels valid with in_data[i]=8'h10+i, out_ready=1 -> outputs 8'h10, 8'h11, ..., 8'h1F, 8'h10 on consecutive cycles, with out_sel 0..15 then wrapping to 0. No bubbles.
3. Only channels 3 and 12 valid, out_ready=1 -> grants alternate 3, 12, 3, 12. out_sel matches and out_data equals the respective channel data.
4. out_ready=0 for 5 cycles after out_data=8'hA5 from channel 7 -> out_data=8'hA5, out_sel=7, out_valid=1 stable and in_ready=0 for all 5 cycles. Transfer resumes the cycle out_ready=1.
5. rst asserted while out_valid=1 and channels 2 and 9 valid -> next cycle out_valid=0 and ptr=0. After release, channel 2 is granted before channel 9.
6. With RR_STREAM_MUX_PKT_LOCK_EN, ch1 sends a 3-beat packet (last on beat 3) while ch0 and ch2 are valid -> beats 1, 2, 3 from ch1 are contiguous, out_last=1 only on beat 3, and the next grant is ch2.
